// File: rtl/mizhi_mem_pkg.sv
// Shared constants and types for the multi-port byte-addressed memory.
package mizhi_mem_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/rd_resp_slot.sv
// One-entry read response slot with valid/ready handshakes on both sides.
module rd_resp_slot
    import mizhi_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_err_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic                  resp_err_o
);

    slot_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic                  accept_c;

    // A new request can land whenever the current response leaves this cycle.
    assign req_ready_o = (state_q == EMPTY) || resp_ready_i;
    assign accept_c    = req_valid_i && req_ready_o;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        err_d   = err_q;
        if (accept_c) begin
            state_d = FULL;
            data_d  = mem_data_i;
            err_d   = mem_err_i;
        end else if ((state_q == FULL) && resp_ready_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid_o = (state_q == FULL);
    assign resp_data_o  = data_q;
    assign resp_err_o   = err_q;

endmodule

// File: rtl/multi_port_mem.sv
// Byte-addressed memory with masked unaligned write ports and handshaked read ports.
module multi_port_mem
    import mizhi_mem_pkg::*;
#(
    parameter  int unsigned NUM_BYTES  = 2097152,
    parameter  int unsigned DATA_WIDTH = 64,
    parameter  int unsigned NUM_WR     = 2,
    parameter  int unsigned NUM_RD     = 3,
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_BYTES),
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / BYTE_W
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_WR-1:0]                    wr_en,
    input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]    wr_addr,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wr_data,
    input  logic [NUM_WR-1:0][MASK_WIDTH-1:0]    wr_mask,
    input  logic [NUM_RD-1:0]                    rd_req_valid,
    output logic [NUM_RD-1:0]                    rd_req_ready,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    rd_req_addr,
    output logic [NUM_RD-1:0]                    rd_resp_valid,
    input  logic [NUM_RD-1:0]                    rd_resp_ready,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_resp_data,
    output logic [NUM_RD-1:0]                    rd_resp_err
);

    localparam int unsigned EXT_W = ADDR_WIDTH + 1;

    logic [BYTE_W-1:0] mem_q [NUM_BYTES];

    logic [NUM_WR-1:0]                 wr_ok_c;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data_c;
    logic [NUM_RD-1:0]                 rd_err_c;

    // True when every lane of an access starting at a falls inside the array.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (EXT_W'(a) + EXT_W'(MASK_WIDTH)) <= EXT_W'(NUM_BYTES);
    endfunction

    always_comb begin
        wr_ok_c = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            wr_ok_c[p] = wr_en[p] && in_range(wr_addr[p]);
        end
    end

    // Later ports overwrite earlier ones, so the highest index wins a shared byte.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_ok_c[p]) begin
                    for (int i = 0; i < MASK_WIDTH; i++) begin
                        if (wr_mask[p][i]) begin
                            mem_q[wr_addr[p] + ADDR_WIDTH'(i)] <= wr_data[p][i*BYTE_W +: BYTE_W];
                        end
                    end
                end
            end
        end
    end

    // Pre-edge memory view, which gives read-before-write on a same-cycle collision.
    always_comb begin
        rd_data_c = '0;
        rd_err_c  = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_err_c[r] = !in_range(rd_req_addr[r]);
            if (!rd_err_c[r]) begin
                for (int i = 0; i < MASK_WIDTH; i++) begin
                    rd_data_c[r][i*BYTE_W +: BYTE_W] = mem_q[rd_req_addr[r] + ADDR_WIDTH'(i)];
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        rd_resp_slot #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .req_valid_i  (rd_req_valid[r]),
            .req_ready_o  (rd_req_ready[r]),
            .mem_data_i   (rd_data_c[r]),
            .mem_err_i    (rd_err_c[r]),
            .resp_valid_o (rd_resp_valid[r]),
            .resp_ready_i (rd_resp_ready[r]),
            .resp_data_o  (rd_resp_data[r]),
            .resp_err_o   (rd_resp_err[r])
        );
    end

endmodule

// File: doc/multi_port_mem.md
MULTI_PORT_MEM -- requirements
Module: multi_port_mem

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 2097152: memory size in bytes.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: port data width in bits, a multiple of 8.
REQ-003 SHALL have parameter NUM_WR, default 2: number of write ports.
REQ-004 SHALL have parameter NUM_RD, default 3: number of read ports.
REQ-005 SHALL derive ADDR_WIDTH = clog2(NUM_BYTES) and MASK_WIDTH = DATA_WIDTH/8.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port wr_en, input, NUM_WR: per-port write enable.
REQ-010 SHALL have port wr_addr, input, NUM_WR x ADDR_WIDTH: byte address of lane 0.
REQ-011 SHALL have port wr_data, input, NUM_WR x DATA_WIDTH: write data; lane i is bits [8i+7:8i].
REQ-012 SHALL have port wr_mask, input, NUM_WR x MASK_WIDTH: per-lane byte enable.
REQ-013 SHALL have port rd_req_valid, input, NUM_RD: read request valid.
REQ-014 SHALL have port rd_req_ready, output, NUM_RD: read request accepted when valid and ready are both high.
REQ-015 SHALL have port rd_req_addr, input, NUM_RD x ADDR_WIDTH: byte address of lane 0.
REQ-016 SHALL have port rd_resp_valid, output, NUM_RD: response valid.
REQ-017 SHALL have port rd_resp_ready, input, NUM_RD: consumer ready for the response.
REQ-018 SHALL have port rd_resp_data, output, NUM_RD x DATA_WIDTH: read data.
REQ-019 SHALL have port rd_resp_err, output, NUM_RD: the request was out of range.

Function
REQ-020 SHALL accept addresses without any alignment restriction; lane i addresses byte addr+i.
REQ-021 SHALL write byte addr+i on a write port when its wr_en is high and wr_mask[i] is high; writes take effect at the clock edge and are always accepted.
REQ-022 SHALL treat a write with addr+MASK_WIDTH > NUM_BYTES as fully dropped: no byte is written and there is no wrap-around.
REQ-023 SHALL, when several write ports write the same byte in one cycle, store the data from the highest-indexed port.
REQ-024 SHALL have a per-read-port response slot; each slot is in state EMPTY or FULL.
REQ-025 SHALL drive rd_req_ready = EMPTY or (FULL and rd_resp_ready), a combinational function of slot state and rd_resp_ready only.
REQ-026 SHALL, on request acceptance, capture memory data at the edge into the slot, with a latency of exactly 1 cycle to rd_resp_valid.
REQ-027 SHALL return pre-write (old) data when a request is accepted in the same cycle as a write to the same bytes.
REQ-028 SHALL keep captured response data, and rd_resp_err, stable while FULL and not consumed, even if memory is later written.
REQ-029 SHALL move the slot from FULL to EMPTY on rd_resp_ready with no new acceptance, stay FULL on simultaneous consume and accept (new data loaded), and move from EMPTY to FULL on acceptance.
REQ-030 SHALL, for a read with addr+MASK_WIDTH > NUM_BYTES, respond with rd_resp_err=1 and rd_resp_data=0.
REQ-031 SHALL keep read ports fully independent; the same address on all ports is legal.

Reset
REQ-032 SHALL, while rst_n is low, drive rd_resp_valid=0, rd_resp_err=0, rd_resp_data=0 and rd_req_ready=1.
REQ-033 SHALL discard pending responses on reset mid-operation.
REQ-034 SHALL leave memory contents unreset and ignore writes while rst_n is low.

Structure
REQ-035 SHALL place the byte-lane width constant (8) and the slot state enum (EMPTY/FULL) in the shared package mizhi_mem_pkg.
REQ-036 SHALL implement the per-port slot and handshake as one sub-module, rd_resp_slot, instantiated NUM_RD times.

Verification
REQ-037 SHALL check: port 0 writes 0x1122334455667788 at 0x10 with mask 0xFF, then port 1 reads 0x10 -> 0x1122334455667788 one cycle after acceptance.
REQ-038 SHALL check: wr0 and wr1 both write 0x20 in the same cycle, wr0 with data 0xAA.. mask 0xFF and wr1 with data 0xBB.. mask 0x0F -> read 0x20 returns 0xAAAAAAAABBBBBBBB.
REQ-039 SHALL check: an unaligned read at 0x13 after REQ-037 -> 0x??1122334455 upper lanes correct, lower five bytes equal 0x1122334455.
REQ-040 SHALL check: hold rd_resp_ready=0 for 5 cycles, then write the same address -> rd_resp_data unchanged and rd_req_ready=0 throughout, then 1 once ready rises.
REQ-041 SHALL check: a read at NUM_BYTES-4 -> rd_resp_err=1 and data 0; a write at NUM_BYTES-4 leaves the last 4 bytes unchanged.
REQ-042 SHALL check: assert rst_n low while a response is FULL -> rd_resp_valid falls asynchronously, and memory data written before reset reads back intact after reset.
